aes_v3: RTL and testbench

AES_V3 -- requirements
Module: aes_v3

---
 rtl/aes_v3_pkg.sv | 38 +++
 rtl/aes_sbox.sv | 46 ++++
 rtl/aes_v3_lane.sv | 44 ++++
 rtl/aes_v3.sv | 162 ++++++++++++++++
 tb/tb_aes_v3.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_v3_pkg.sv
// aes_v3_pkg -- definitions shared by the aes_v3 slice.
//   state_t      : FSM state encoding (IDLE / RUN)
//   LANES_LEGAL  : bit n set when LANES == n is a legal configuration
//   lanes_ok()   : elaboration-time LANES check built on LANES_LEGAL
//   xtime()      : multiply by x (0x02) in GF(2^8) mod 0x11b
//   gf_mul()     : general GF(2^8) multiply built from xtime
package aes_v3_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Legal lane counts are 1, 2 and 4.
  localparam logic [4:0] LANES_LEGAL = 5'b10110;

  function automatic logic lanes_ok(input int l);
    if (l < 0 || l > 4) return 1'b0;
    return LANES_LEGAL[l[2:0]];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] r;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox -- combinational AES S-box, computed as GF(2^8) inverse plus affine map.
// Optional feature macro: AES_V3_DECRYPT_EN (adds the inverse S-box).
// Ports:
//   enc : 1 = forward S-box, 0 = inverse S-box (0x00 when inverse is not built)
//   x   : input byte
//   y   : substituted byte
module aes_sbox
  import aes_v3_pkg::*;
(
  input  logic       enc,
  input  logic [7:0] x,
  output logic [7:0] y
);

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  logic [7:0] fwd;

  always_comb fwd = affine_fwd(gf_inv(x));

`ifdef AES_V3_DECRYPT_EN
  function automatic logic [7:0] affine_inv(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  always_comb y = enc ? fwd : gf_inv(affine_inv(x));
`else
  always_comb y = enc ? fwd : 8'h00;
`endif

endmodule

// File: rtl/aes_v3_lane.sv
// aes_v3_lane -- one byte lane: an S-box and one MixColumn output byte.
// Optional feature macro: AES_V3_DECRYPT_EN (adds inverse MixColumn).
// Ports:
//   sub         : 1 = S-box result, 0 = MixColumn result
//   enc         : 1 = encrypt, 0 = decrypt
//   sb_x        : S-box input byte
//   c0..c3      : column bytes rotated so c0 is this lane's own byte
//   y           : lane result byte
module aes_v3_lane
  import aes_v3_pkg::*;
(
  input  logic       sub,
  input  logic       enc,
  input  logic [7:0] sb_x,
  input  logic [7:0] c0,
  input  logic [7:0] c1,
  input  logic [7:0] c2,
  input  logic [7:0] c3,
  output logic [7:0] y
);

  logic [7:0] sb_y;
  logic [7:0] mix_enc;
  logic [7:0] mix;

  aes_sbox u_sbox (
    .enc (enc),
    .x   (sb_x),
    .y   (sb_y)
  );

  always_comb mix_enc = xtime(c0) ^ xtime(c1) ^ c1 ^ c2 ^ c3;

`ifdef AES_V3_DECRYPT_EN
  logic [7:0] mix_dec;
  always_comb mix_dec = gf_mul(c0, 8'h0e) ^ gf_mul(c1, 8'h0b) ^ gf_mul(c2, 8'h0d) ^ gf_mul(c3, 8'h09);
  always_comb mix = enc ? mix_enc : mix_dec;
`else
  always_comb mix = enc ? mix_enc : 8'h00;
`endif

  always_comb y = sub ? sb_y : mix;

endmodule

// File: rtl/aes_v3.sv
// aes_v3 -- multi-cycle AES SubBytes / MixColumn instruction unit.
// Processes LANES bytes per cycle; result appears on rd with a one-cycle
// ready pulse 4/LANES cycles after the request is accepted.
// Optional feature macro: AES_V3_DECRYPT_EN (inverse S-box and inverse
// MixColumn; without it decrypt requests return 32'h0).
// Ports:
//   g_clk, g_resetn : clock, asynchronous active-low reset
//   valid           : request strobe (accepted when idle)
//   sub             : 1 = SubBytes, 0 = MixColumn
//   enc             : 1 = encrypt, 0 = decrypt
//   rs1, rs2        : source operands
//   flush           : abort the in-flight operation
//   busy            : operation in flight (through the ready cycle)
//   ready           : one-cycle completion pulse
//   rd              : registered result
module aes_v3
  import aes_v3_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        sub,
  input  logic        enc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rd
);

  localparam int STEPS = lanes_ok(LANES) ? 4 / LANES : 1;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  if (!lanes_ok(LANES)) begin : g_bad_lanes
    $error("aes_v3: LANES must be 1, 2 or 4");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             step;
  logic             last;

  logic [31:0]      rs1_p0, rs2_p0;
  logic             sub_p0, enc_p0;
  logic [3:0][7:0]  acc_p1;
  logic [3:0][7:0]  res;

  logic [7:0]       sb_src [4];
  logic [7:0]       col    [4];
  logic [7:0]       lane_y [LANES];
  logic [1:0]       lane_k [LANES];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // flush outranks valid
        if (valid && !flush) begin
          accept  = 1'b1;
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          step = 1'b1;
          if (cnt_q == LAST_STEP) begin
            last    = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready   <= 1'b0;
      rd      <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready   <= last;
      if (last) rd <= res;
    end
  end

  // ready is registered off the last step, so busy spans the ready cycle too;
  // acceptance only looks at the FSM state, which allows back-to-back issue.
  always_comb busy = (state_q == ST_RUN) | ready;

  // ---- stage p0: operands captured at acceptance ----
  always_ff @(posedge g_clk) begin
    if (accept) begin
      rs1_p0 <= rs1;
      rs2_p0 <= rs2;
      sub_p0 <= sub;
      enc_p0 <= enc;
    end
  end

  always_comb begin
    sb_src[0] = rs1_p0[7:0];
    sb_src[1] = rs2_p0[15:8];
    sb_src[2] = rs1_p0[23:16];
    sb_src[3] = rs2_p0[31:24];
    col[0]    = rs1_p0[7:0];
    col[1]    = rs1_p0[15:8];
    col[2]    = rs2_p0[23:16];
    col[3]    = rs2_p0[31:24];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [1:0] k;
    // byte index handled by this lane in the current step; 2-bit sums wrap mod 4
    assign k         = 2'((int'(cnt_q) * LANES) + l);
    assign lane_k[l] = k;

    aes_v3_lane u_lane (
      .sub  (sub_p0),
      .enc  (enc_p0),
      .sb_x (sb_src[k]),
      .c0   (col[k]),
      .c1   (col[k + 2'd1]),
      .c2   (col[k + 2'd2]),
      .c3   (col[k + 2'd3]),
      .y    (lane_y[l])
    );
  end

  always_comb begin
    res = acc_p1;
    for (int l = 0; l < LANES; l++) res[lane_k[l]] = lane_y[l];
  end

  // ---- stage p1: partial result accumulator, kept off rd until done ----
  always_ff @(posedge g_clk) begin
    if (step) acc_p1 <= res;
  end

endmodule

// File: tb/tb_aes_v3.sv
// tb_aes_v3 -- scoreboard bench for aes_v3 with LANES = 1, 2 and 4 instances.
// Stimulus pushes expected {rd, completion cycle} per instance; a negedge
// monitor pops on every ready pulse and compares.
// Optional feature macro: AES_V3_DECRYPT_EN (changes decrypt expectations).
module tb_aes_v3;

`ifdef AES_V3_DECRYPT_EN
  localparam logic [31:0] EXP_DEC_MIX = 32'h455313db;
  localparam logic [31:0] EXP_INV_SB  = 32'hff531001;
  localparam logic [31:0] EXP_INV_SB0 = 32'h52525252;
`else
  localparam logic [31:0] EXP_DEC_MIX = 32'h0;
  localparam logic [31:0] EXP_INV_SB  = 32'h0;
  localparam logic [31:0] EXP_INV_SB0 = 32'h0;
`endif

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] due;
  } exp_t;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        valid_a [3];
  logic        sub_a   [3];
  logic        enc_a   [3];
  logic [31:0] rs1_a   [3];
  logic [31:0] rs2_a   [3];
  logic        flush_a [3];
  logic        busy_a  [3];
  logic        ready_a [3];
  logic [31:0] rd_a    [3];
  logic [31:0] last_exp [3];

  logic [31:0] cyc = 32'd0;
  int          errors = 0;
  int          checks = 0;
  exp_t        q0[$], q1[$], q2[$];

  always #5 g_clk = ~g_clk;
  always @(posedge g_clk) cyc <= cyc + 32'd1;

  aes_v3 #(.LANES(1)) u_l1 (.g_clk(g_clk), .g_resetn(g_resetn), .valid(valid_a[0]), .sub(sub_a[0]),
    .enc(enc_a[0]), .rs1(rs1_a[0]), .rs2(rs2_a[0]), .flush(flush_a[0]), .busy(busy_a[0]),
    .ready(ready_a[0]), .rd(rd_a[0]));
  aes_v3 #(.LANES(2)) u_l2 (.g_clk(g_clk), .g_resetn(g_resetn), .valid(valid_a[1]), .sub(sub_a[1]),
    .enc(enc_a[1]), .rs1(rs1_a[1]), .rs2(rs2_a[1]), .flush(flush_a[1]), .busy(busy_a[1]),
    .ready(ready_a[1]), .rd(rd_a[1]));
  aes_v3 #(.LANES(4)) u_l4 (.g_clk(g_clk), .g_resetn(g_resetn), .valid(valid_a[2]), .sub(sub_a[2]),
    .enc(enc_a[2]), .rs1(rs1_a[2]), .rs2(rs2_a[2]), .flush(flush_a[2]), .busy(busy_a[2]),
    .ready(ready_a[2]), .rd(rd_a[2]));

  function automatic int lat(input int d);
    return (d == 0) ? 4 : (d == 1) ? 2 : 1;
  endfunction

  function automatic int pending();
    return q0.size() + q1.size() + q2.size();
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_exp(input int d, input logic [31:0] rdv, input logic [31:0] due);
    exp_t e;
    e.rd  = rdv;
    e.due = due;
    last_exp[d] = rdv;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic issue(input int d, input logic s, input logic e, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] rdv, input bit push);
    sub_a[d]   = s;
    enc_a[d]   = e;
    rs1_a[d]   = a;
    rs2_a[d]   = b;
    valid_a[d] = 1'b1;
    @(posedge g_clk);
    #1;
    if (push) push_exp(d, rdv, cyc + 32'(lat(d)));
    @(negedge g_clk);
    valid_a[d] = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && pending() != 0; i++) @(negedge g_clk);
    @(negedge g_clk);
    if (pending() != 0) begin
      checks++;
      errors++;
      $display("FAIL completion_timeout: %0d results still outstanding, required 0", pending());
      q0.delete();
      q1.delete();
      q2.delete();
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    bit   have;
    if (ready_a[d] !== 1'b1) return;
    have = 1'b0;
    case (d)
      0: if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL lanes_inst%0d unexpected_ready: rd=%h, required no ready pulse", d, rd_a[d]);
    end else if (rd_a[d] !== e.rd || cyc !== e.due || busy_a[d] !== 1'b1) begin
      errors++;
      $display("FAIL lanes_inst%0d result: rd=%h cycle=%0d busy=%b, required rd=%h cycle=%0d busy=1",
               d, rd_a[d], cyc, busy_a[d], e.rd, e.due);
    end
  endtask

  always @(negedge g_clk) begin
    if (g_resetn) begin
      for (int d = 0; d < 3; d++) mon(d);
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      valid_a[d] = 1'b0; sub_a[d] = 1'b0; enc_a[d] = 1'b0;
      rs1_a[d] = 32'h0; rs2_a[d] = 32'h0; flush_a[d] = 1'b0; last_exp[d] = 32'h0;
    end
    repeat (2) @(negedge g_clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("reset_state_inst%0d", d), {busy_a[d], ready_a[d], rd_a[d]}, 34'h0);
    g_resetn = 1'b1;
    @(negedge g_clk);

    // Forward SubBytes of zero on LANES=1
    issue(0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h63636363, 1'b1);
    wait_done();

    // MixColumn encrypt and decrypt on every lane count
    for (int d = 0; d < 3; d++) begin
      issue(d, 1'b0, 1'b1, 32'h000013db, 32'h45530000, 32'hbca14d8e, 1'b1);
      wait_done();
      issue(d, 1'b0, 1'b0, 32'h00004d8e, 32'hbca10000, EXP_DEC_MIX, 1'b1);
      wait_done();
    end

    // SubBytes byte selection (junk bytes in unused positions)
    issue(1, 1'b1, 1'b1, 32'haa53bb01, 32'hffcc10dd, 32'h16edca7c, 1'b1);
    wait_done();
    issue(1, 1'b1, 1'b0, 32'h00ed007c, 32'h1600ca00, EXP_INV_SB, 1'b1);
    wait_done();
    issue(2, 1'b0, 1'b1, 32'h11110af2, 32'h5c223333, 32'h9d58dc9f, 1'b1);
    wait_done();
    issue(2, 1'b1, 1'b0, 32'h0, 32'h0, EXP_INV_SB0, 1'b1);
    wait_done();

    // Flush on LANES=1 during the second cycle; rd must hold
    issue(0, 1'b1, 1'b1, 32'h01010101, 32'h01010101, 32'h0, 1'b0);
    @(negedge g_clk);
    flush_a[0] = 1'b1;
    @(negedge g_clk);
    flush_a[0] = 1'b0;
    check("flush_busy_low", {31'h0, busy_a[0]}, 32'h0);
    check("flush_rd_held", rd_a[0], last_exp[0]);
    issue(0, 1'b0, 1'b1, 32'h000013db, 32'h45530000, 32'hbca14d8e, 1'b1);
    wait_done();

    // flush and valid together while idle: no acceptance
    valid_a[0] = 1'b1;
    flush_a[0] = 1'b1;
    @(negedge g_clk);
    valid_a[0] = 1'b0;
    flush_a[0] = 1'b0;
    check("flush_beats_valid_busy", {31'h0, busy_a[0]}, 32'h0);
    repeat (6) @(negedge g_clk);

    // LANES=2: mid-operation valid ignored, back-to-back in the ready cycle
    issue(1, 1'b0, 1'b1, 32'h000013db, 32'h45530000, 32'hbca14d8e, 1'b1);
    check("midop_busy_high", {31'h0, busy_a[1]}, 32'h1);
    sub_a[1] = 1'b1; enc_a[1] = 1'b1; rs1_a[1] = 32'h12345678; rs2_a[1] = 32'h9abcdef0;
    valid_a[1] = 1'b1;
    @(negedge g_clk);
    valid_a[1] = 1'b0;
    @(negedge g_clk);
    issue(1, 1'b1, 1'b1, 32'h0, 32'h0, 32'h63636363, 1'b1);
    wait_done();

    // LANES=2: reset pulse mid-operation
    issue(1, 1'b0, 1'b1, 32'h11110af2, 32'h5c223333, 32'h0, 1'b0);
    check("pre_reset_busy", {31'h0, busy_a[1]}, 32'h1);
    g_resetn = 1'b0;
    #1;
    check("reset_midop_rd", rd_a[1], 32'h0);
    check("reset_midop_busy_ready", {30'h0, busy_a[1], ready_a[1]}, 32'h0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    repeat (6) @(negedge g_clk);
    check("outstanding_at_end", 32'(pending()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t, required completion earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
